// File: rtl/phy_pkg.sv
// -----------------------------------------------------------------------------
// phy_pkg
// Shared definitions for the lane path: the byte width of a mux lane, the
// idle/training symbol, the lane byte type and the serializer state encoding.
// Also holds the bit-counter width and a small helper for word boundaries.
// -----------------------------------------------------------------------------
package phy_pkg;

   // Width of one byte lane leaving the 4-to-2 lane mux
   localparam int BYTE_W = 8;

   // Comma symbol used both for the training preamble and for idle fill
   localparam logic [BYTE_W-1:0] COM_SYM = 8'hBC;

   // Bits needed to count positions 0..BYTE_W-1 inside a serialized word
   localparam int CNT_W = $clog2(BYTE_W);

   // One byte as carried on a mux lane
   typedef logic [BYTE_W-1:0] lane_byte_t;

   // Serializer state: preamble first, then data/idle forever
   typedef enum logic {
      INIT   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   // A bit position of zero marks the first bit of a new word (load edge)
   function automatic logic word_start(input logic [CNT_W-1:0] pos);
      return (pos == '0);
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Small first-word-fall-through byte FIFO. The head entry is always visible on
// dout so a consumer can pop and use it on the same edge.
//
// Ports
//   clk    in   clock, rising edge
//   reset  in   asynchronous, active-high; empties the FIFO
//   push   in   write din on this edge
//   pop    in   drop the head entry on this edge
//   din    in   byte to write
//   dout   out  current head entry (valid while empty is low)
//   count  out  number of stored entries, 0..DEPTH
//   full   out  count == DEPTH
//   empty  out  count == 0
//
// The caller qualifies push and pop: push only when not full or when a pop
// happens on the same edge, pop only when not empty. A push and pop on the
// same edge while full is legal: the head is read out before the write slot
// (which equals the head slot when full) is overwritten at the clock edge.
// -----------------------------------------------------------------------------
module byte_fifo
   import phy_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [BYTE_W-1:0] din,
   output logic [BYTE_W-1:0] dout,
   output logic [CW-1:0]     count,
   output logic              full,
   output logic              empty
);

   logic [BYTE_W-1:0] mem [DEPTH];

   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;

   // Storage carries no reset; only the pointers and count define contents
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign dout  = mem[rd_ptr_reg];
   assign count = count_reg;
   assign full  = (count_reg == CW'(DEPTH));
   assign empty = (count_reg == '0);

endmodule

// File: rtl/lane_serializer.sv
// -----------------------------------------------------------------------------
// lane_serializer
// Consumes one byte lane from the lane mux, buffers accepted bytes in a FIFO
// and serializes them MSB-first at one bit per clock. After reset a preamble of
// INIT_COMS COM words is sent; afterwards COM fills every word slot for which
// no byte is buffered.
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   asynchronous, active-high
//   data_in     in   byte from the mux lane
//   valid_in    in   data_in is offered to the FIFO on this edge
//   data_out    out  serial bit, registered
//   active_out  out  high while the word on data_out is a FIFO byte
//   fifo_full   out  FIFO holds DEPTH bytes
//   overflow    out  sticky: a byte was dropped since reset
//
// A word slot is 8 edges long; the edge where cnt is 0 loads the next word.
// -----------------------------------------------------------------------------
module lane_serializer
   import phy_pkg::*;
#(
   parameter int              DEPTH     = 4,
   parameter logic [BYTE_W-1:0] COM     = COM_SYM,
   parameter int              INIT_COMS = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BYTE_W-1:0] data_in,
   input  logic              valid_in,
   output logic              data_out,
   output logic              active_out,
   output logic              fifo_full,
   output logic              overflow
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int IW = $clog2(INIT_COMS + 1);

   state_t            state_reg,    state_next;
   logic [CNT_W-1:0]  cnt_reg,      cnt_next;
   logic [IW-1:0]     init_cnt_reg, init_cnt_next;
   // Holds the not-yet-sent bits 6..0 of the current word; bit 7 goes
   // straight to data_out on the load edge.
   logic [BYTE_W-2:0] shreg_reg,    shreg_next;
   logic              data_out_reg, data_out_next;
   logic              active_reg,   active_next;
   logic              overflow_reg, overflow_next;

   lane_byte_t        word;
   logic              load;
   logic              push;
   logic              pop;

   lane_byte_t        fifo_dout;
   logic [CW-1:0]     fifo_count;
   logic              fifo_full_int;
   logic              fifo_empty;

   byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (data_in),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full_int),
      .empty (fifo_empty)
   );

   assign load = word_start(cnt_reg);

   // Pop uses the pre-edge empty flag, so a byte written on a load edge into
   // an empty FIFO waits for the following word slot (no bypass).
   assign pop  = load && (state_reg == ACTIVE) && !fifo_empty;

   // A full FIFO still accepts a write when the head leaves on the same edge
   assign push = valid_in && (!fifo_full_int || pop);

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg + 1'b1;
      init_cnt_next = init_cnt_reg;
      word          = COM;
      shreg_next    = {shreg_reg[BYTE_W-3:0], 1'b0};
      data_out_next = shreg_reg[BYTE_W-2];
      active_next   = active_reg;
      overflow_next = overflow_reg | (valid_in & ~push);

      if (load) begin
         active_next = 1'b0;
         case (state_reg)
            INIT: begin
               // The switch happens on the load edge of the last preamble
               // word, so the next load edge already serves the FIFO.
               init_cnt_next = init_cnt_reg + 1'b1;
               if (init_cnt_reg == IW'(INIT_COMS - 1)) begin
                  state_next = ACTIVE;
               end
            end
            ACTIVE: begin
               if (pop) begin
                  word        = fifo_dout;
                  active_next = 1'b1;
               end
            end
            default: begin
               state_next = INIT;
            end
         endcase
         shreg_next    = word[BYTE_W-2:0];
         data_out_next = word[BYTE_W-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= INIT;
         cnt_reg      <= '0;
         init_cnt_reg <= '0;
         shreg_reg    <= '0;
         data_out_reg <= 1'b0;
         active_reg   <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         init_cnt_reg <= init_cnt_next;
         shreg_reg    <= shreg_next;
         data_out_reg <= data_out_next;
         active_reg   <= active_next;
         overflow_reg <= overflow_next;
      end
   end

   assign data_out   = data_out_reg;
   assign active_out = active_reg;
   assign overflow   = overflow_reg;
   assign fifo_full  = (fifo_count == CW'(DEPTH));

endmodule

// File: tb/tb_lane_serializer.sv
// -----------------------------------------------------------------------------
// tb_lane_serializer
// Directed bench for lane_serializer with default parameters (DEPTH=4,
// COM=8'hBC, INIT_COMS=4). Inputs change and outputs are sampled on the
// falling clock edge; the value seen after rising edge k is the bit loaded
// on edge k. Edge 0 is the first rising edge after reset is released, so
// word n of the stream starts on edge 8n.
// -----------------------------------------------------------------------------
module tb_lane_serializer;

   logic       clk;
   logic       reset;
   logic [7:0] data_in;
   logic       valid_in;
   logic       data_out;
   logic       active_out;
   logic       fifo_full;
   logic       overflow;

   int total = 0;
   int bad   = 0;

   localparam logic [7:0] C = 8'hBC;

   lane_serializer #(
      .DEPTH     (4),
      .COM       (8'hBC),
      .INIT_COMS (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .valid_in   (valid_in),
      .data_out   (data_out),
      .active_out (active_out),
      .fifo_full  (fifo_full),
      .overflow   (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input string what, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s %s observed=%b expected=%b", tag, what, obs, exp);
      end
   endtask

   // Assert reset right now, check the outputs clear without a clock edge,
   // then release on a falling edge so the next rising edge is edge 0.
   task automatic do_reset(input string tag);
      valid_in = 1'b0;
      reset    = 1'b1;
      #1;
      chk(tag, "data_out",   data_out,   1'b0);
      chk(tag, "active_out", active_out, 1'b0);
      chk(tag, "overflow",   overflow,   1'b0);
      chk(tag, "fifo_full",  fifo_full,  1'b0);
      $display("%s reset applied data_out=%b active=%b ovf=%b full=%b",
               tag, data_out, active_out, overflow, fifo_full);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // One word slot of nbits edges. Bit i of wmask offers byte i of wdata on
   // the i-th edge of the slot; fullm/ovfm give expected flags after each edge.
   task automatic expect_word(input string tag, input logic [7:0] word, input logic act,
                              input logic [7:0] wmask, input logic [63:0] wdata,
                              input logic [7:0] fullm, input logic [7:0] ovfm,
                              input int nbits = 8);
      logic [7:0] seen;
      seen = '0;
      for (int i = 0; i < nbits; i++) begin
         valid_in = wmask[i];
         data_in  = wdata[8*i +: 8];
         @(negedge clk);
         valid_in = 1'b0;
         seen[7-i] = data_out;
         chk(tag, $sformatf("data_out[%0d]", 7-i), data_out, word[7-i]);
         chk(tag, $sformatf("active_out@%0d", i), active_out, act);
         chk(tag, $sformatf("fifo_full@%0d", i), fifo_full, fullm[i]);
         chk(tag, $sformatf("overflow@%0d", i), overflow, ovfm[i]);
      end
      $display("%s bits=%b (%0d sent) active=%b full=%b ovf=%b",
               tag, seen, nbits, active_out, fifo_full, overflow);
   endtask

   initial begin
      reset    = 1'b0;
      valid_in = 1'b0;
      data_in  = 8'h00;

      // Preamble with no writes: 4 COM words, then COM idle
      do_reset("rst0");
      for (int w = 0; w < 4; w++) begin
         expect_word($sformatf("t1_pre%0d", w), C, 1'b0, 8'h00, 64'h0, 8'h00, 8'h00);
      end
      expect_word("t1_idle", C, 1'b0, 8'h00, 64'h0, 8'h00, 8'h00);

      // 0xA5 written on edge 3 (INIT) comes out on the load edge at cycle 32
      do_reset("rst1");
      expect_word("t2_pre0", C, 1'b0, 8'h08, 64'h00000000_A5000000, 8'h00, 8'h00);
      for (int w = 1; w < 4; w++) begin
         expect_word($sformatf("t2_pre%0d", w), C, 1'b0, 8'h00, 64'h0, 8'h00, 8'h00);
      end
      expect_word("t2_data", 8'hA5, 1'b1, 8'h00, 64'h0, 8'h00, 8'h00);
      expect_word("t2_idle", C, 1'b0, 8'h00, 64'h0, 8'h00, 8'h00);

      // Three writes starting on a load edge into an empty FIFO: that slot is
      // still COM, then three back-to-back data words
      expect_word("t3_wr", C, 1'b0, 8'h07, 64'h00000000_00030201, 8'h00, 8'h00);
      expect_word("t3_d01", 8'h01, 1'b1, 8'h00, 64'h0, 8'h00, 8'h00);
      expect_word("t3_d02", 8'h02, 1'b1, 8'h00, 64'h0, 8'h00, 8'h00);
      expect_word("t3_d03", 8'h03, 1'b1, 8'h00, 64'h0, 8'h00, 8'h00);
      expect_word("t3_idle", C, 1'b0, 8'h00, 64'h0, 8'h00, 8'h00);

      // Six writes on consecutive edges with cnt=4..7,0,1: four fill the FIFO,
      // the fifth lands on a load edge (pop+push, count stays 4, no overflow),
      // the sixth is dropped and overflow latches
      expect_word("t4_wr", C, 1'b0, 8'hF0, 64'h13121110_00000000, 8'h80, 8'h00);
      expect_word("t4_d10", 8'h10, 1'b1, 8'h03, 64'h00000000_00001514, 8'hFF, 8'hFE);
      expect_word("t4_d11", 8'h11, 1'b1, 8'h00, 64'h0, 8'h00, 8'hFF);
      expect_word("t4_d12", 8'h12, 1'b1, 8'h00, 64'h0, 8'h00, 8'hFF);
      expect_word("t4_d13", 8'h13, 1'b1, 8'h00, 64'h0, 8'h00, 8'hFF);
      expect_word("t4_d14", 8'h14, 1'b1, 8'h00, 64'h0, 8'h00, 8'hFF);
      expect_word("t4_idle", C, 1'b0, 8'h00, 64'h0, 8'h00, 8'hFF);

      // Queue 0xF0 and 0x77, then reset halfway through 0xF0 (cnt=4)
      expect_word("t5_wr", C, 1'b0, 8'h03, 64'h00000000_000077F0, 8'h00, 8'hFF);
      expect_word("t5_f0", 8'hF0, 1'b1, 8'h00, 64'h0, 8'h00, 8'hFF, 4);
      do_reset("rst_mid");

      // Preamble restarts; the queued 0x77 is gone and overflow is clear
      for (int w = 0; w < 4; w++) begin
         expect_word($sformatf("t5_pre%0d", w), C, 1'b0, 8'h00, 64'h0, 8'h00, 8'h00);
      end
      expect_word("t5_idle", C, 1'b0, 8'h00, 64'h0, 8'h00, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
